reset_event_sync: RTL
=====================

// Module: reset_event_sync
// PURPOSE
//  Multi-channel successor to the single-pin GRESET falling-edge synchroniser and PLL-lock power-on counter.
//  Synchronises and debounces CHANNELS asynchronous pins, and reports per-channel edge events with selectable polarity.
//  Generates the system reset: held until PLL lock plus POR_CYCLES, then stretched and retriggered by masked channel events.
//  Sits in the board toplevel between raw input pins and the SoC reset and interrupt inputs.
// PARAMETERS
//  CHANNELS       4    number of input pins handled
//  SYNC_STAGES    2    synchroniser flops per pin (>=2)
//  DEBOUNCE_BITS  16   width of debounce counters and io_debounceLimit
//  POR_CYCLES     255  cycles counted after lock before reset release (>=1)
//  PULSE_CYCLES   16   length of reset pulse caused by a masked event (>=1)
// PORTS
//  io_mainClk       in   1              system clock; all logic on rising edge
//  io_asyncReset_n  in   1              asynchronous, active-low reset of all state
//  io_pllLocked     in   1              PLL lock; asynchronous, synchronised internally (SYNC_STAGES)
//  io_pins          in   CHANNELS       raw asynchronous pin inputs
//  io_edgeMode      in   2*CHANNELS     per channel [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//  io_resetMask     in   CHANNELS       1 = event on this channel triggers a reset pulse
//  io_debounceLimit in   DEBOUNCE_BITS  stability requirement (L); shared by all channels
//  io_level         out  CHANNELS       debounced pin level
//  io_event         out  CHANNELS       one-cycle pulse on each qualifying debounced edge
//  io_resetOut      out  1              active-high system reset
//  io_ready         out  1              1 once POR complete and lock held
// BEHAVIOUR
//  Reset (io_asyncReset_n=0): all flops 0 except FSM=WAIT_LOCK. io_level=0, io_event=0, io_resetOut=1, io_ready=0.
//  Sync: each pin passes SYNC_STAGES flops -> s[i]; no other logic ever reads io_pins.
//  Debounce per channel:
//   - s!=level: cnt+=1. When cnt>=L (">=" so a mid-run limit decrease is safe): level<=s, cnt<=0.
//   - s==level: cnt<=0.
//   - Level updates after L+1 consecutive mismatch cycles. Pin-to-io_level latency = SYNC_STAGES+L+1 cycles.
//   - L=0: update on first mismatch cycle. Glitches shorter than L+1 cycles are ignored.
//  Events:
//   - io_event[i] is registered, asserted in the same cycle io_level[i] changes, for one cycle.
//   - Asserted only if the edge matches the mode; mode 00 never fires.
//   - Suppressed unless FSM in RUN or PULSE.
//  FSM, synchronised lock = lk:
//   - WAIT_LOCK: por_cnt=0. lk=1 -> COUNT.
//   - COUNT: por_cnt+=1. At por_cnt==POR_CYCLES-1 -> RUN, and io_level<=s (all channels, cnt<=0, no events).
//   - RUN: any io_event[i]&io_resetMask[i] -> PULSE, pulse_cnt<=PULSE_CYCLES-1.
//   - PULSE: pulse_cnt==0 -> RUN, else decrement. A new masked event retriggers pulse_cnt<=PULSE_CYCLES-1.
//   - Any state with lk=0 -> WAIT_LOCK next cycle (lk=0 has priority over all events).
//  Outputs (all registered):
//   - io_resetOut = (state!=RUN).
//   - io_ready = state in {RUN, PULSE}.
//   - Debouncers keep running in every state.
//   - Simultaneous events on several channels: each io_event bit fires independently; one pulse results.
//  Widths: por_cnt is clog2(POR_CYCLES) bits and pulse_cnt is clog2(PULSE_CYCLES) bits, each min 1. No wrap is possible.
// STRUCTURE
//  Package reset_event_pkg: EDGE_OFF/RISE/FALL/BOTH 2-bit constants, FSM state typedef (WAIT_LOCK, COUNT, RUN, PULSE).
//  Sub-module debounce_channel (one per channel, generate loop):
//   - contents: sync chain, counter, level, edge qualification.
//   - ports: clk, rst_n, pin, mode, limit, enable, load, level, event.
//  Top holds lock synchroniser, FSM, counters, mask reduction.
// TESTING
//  1 POR: POR_CYCLES=8, lock at cycle 10 -> io_resetOut falls at cycle 10+SYNC_STAGES+8 (+-1 documented); io_ready rises same cycle; no io_event.
//  2 Debounce: L=3, pin0 high 3 cycles then low -> no change; high 10 cycles -> io_level[0] rises 6 cycles after pin edge.
//  3 Modes: ch0=01, ch1=10, ch2=11, ch3=00; toggle all pins high then low -> events ch0:1, ch1:1, ch2:2, ch3:0.
//  4 Reset pulse: PULSE_CYCLES=16, mask=0001, ch0 rise -> io_resetOut high 16 cycles, io_ready stays 1.
//     Second rise 8 cycles in -> total 24 cycles high.
//  5 Lock loss: drop io_pllLocked in RUN -> WAIT_LOCK, io_resetOut=1, io_ready=0; relock -> full POR_CYCLES recount.
//  6 Async reset mid-PULSE and mid-debounce -> all outputs at reset values immediately; pin held high -> no event after release.

Source files
------------

// File: rtl/reset_event_pkg.sv
// Shared constants, FSM state type and edge-qualification helper for reset_event_sync.
package reset_event_pkg;

    localparam logic [1:0] EDGE_OFF  = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        COUNT     = 2'd1,
        RUN       = 2'd2,
        PULSE     = 2'd3
    } state_e;

    // True when a transition to new_level is selected by mode.
    function automatic logic edge_match(input logic [1:0] mode, input logic new_level);
        if (new_level) begin
            return (mode & EDGE_RISE) != EDGE_OFF;
        end
        return (mode & EDGE_FALL) != EDGE_OFF;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One pin: synchroniser chain, stability counter, debounced level and qualified edge pulse.
module debounce_channel
    import reset_event_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned DEBOUNCE_BITS = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pin,
    input  logic [1:0]               mode,
    input  logic [DEBOUNCE_BITS-1:0] limit,
    input  logic                     enable,
    input  logic                     load,
    output logic                     level,
    output logic                     event_o
);

    logic [SYNC_STAGES-1:0]   sync_q, sync_d;
    logic [DEBOUNCE_BITS-1:0] cnt_q, cnt_d;
    logic                     level_q, level_d;
    logic                     event_q, event_d;
    logic                     s_c;

    assign s_c = sync_q[SYNC_STAGES-1];

    // Next-state: shift the synchroniser, count mismatch cycles, commit level after limit+1.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], pin};
        level_d = level_q;
        cnt_d   = cnt_q;
        event_d = 1'b0;
        if (load) begin
            level_d = s_c;
            cnt_d   = '0;
        end else if (s_c != level_q) begin
            // >= keeps a limit lowered mid-run from stranding the counter above it.
            if (cnt_q >= limit) begin
                level_d = s_c;
                cnt_d   = '0;
                event_d = enable && edge_match(mode, s_c);
            end else begin
                cnt_d = cnt_q + DEBOUNCE_BITS'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            event_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            event_q <= event_d;
        end
    end

    assign level   = level_q;
    assign event_o = event_q;

endmodule

// File: rtl/reset_event_sync.sv
// Multi-channel pin debouncer with edge events, plus PLL-lock POR and event-retriggered reset pulse.
module reset_event_sync
    import reset_event_pkg::*;
#(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned DEBOUNCE_BITS = 16,
    parameter int unsigned POR_CYCLES    = 255,
    parameter int unsigned PULSE_CYCLES  = 16
) (
    input  logic                     io_mainClk,
    input  logic                     io_asyncReset_n,
    input  logic                     io_pllLocked,
    input  logic [CHANNELS-1:0]      io_pins,
    input  logic [2*CHANNELS-1:0]    io_edgeMode,
    input  logic [CHANNELS-1:0]      io_resetMask,
    input  logic [DEBOUNCE_BITS-1:0] io_debounceLimit,
    output logic [CHANNELS-1:0]      io_level,
    output logic [CHANNELS-1:0]      io_event,
    output logic                     io_resetOut,
    output logic                     io_ready
);

    localparam int unsigned POR_W   = (POR_CYCLES   > 1) ? $clog2(POR_CYCLES)   : 1;
    localparam int unsigned PULSE_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [POR_W-1:0]   POR_LAST   = POR_W'(POR_CYCLES - 1);
    localparam logic [PULSE_W-1:0] PULSE_LOAD = PULSE_W'(PULSE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] lk_sync_q, lk_sync_d;
    state_e                 state_q, state_d;
    logic [POR_W-1:0]       por_cnt_q, por_cnt_d;
    logic [PULSE_W-1:0]     pulse_cnt_q, pulse_cnt_d;
    logic                   reset_out_q, reset_out_d;
    logic                   ready_q, ready_d;
    logic                   lk_c, load_c, events_en_c, masked_c;

    assign lk_c        = lk_sync_q[SYNC_STAGES-1];
    assign events_en_c = (state_q == RUN) || (state_q == PULSE);
    assign load_c      = (state_q == COUNT) && lk_c && (por_cnt_q == POR_LAST);
    assign masked_c    = |(io_event & io_resetMask);

    // Per-channel debouncers; they run in every state, events gated by the FSM.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .DEBOUNCE_BITS(DEBOUNCE_BITS)
        ) u_ch (
            .clk    (io_mainClk),
            .rst_n  (io_asyncReset_n),
            .pin    (io_pins[i]),
            .mode   (io_edgeMode[2*i +: 2]),
            .limit  (io_debounceLimit),
            .enable (events_en_c),
            .load   (load_c),
            .level  (io_level[i]),
            .event_o(io_event[i])
        );
    end

    // Next-state: lock sync, POR count, pulse stretch/retrigger; lock loss overrides all.
    always_comb begin
        lk_sync_d   = {lk_sync_q[SYNC_STAGES-2:0], io_pllLocked};
        state_d     = state_q;
        por_cnt_d   = por_cnt_q;
        pulse_cnt_d = pulse_cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                por_cnt_d = '0;
                if (lk_c) state_d = COUNT;
            end
            COUNT: begin
                if (por_cnt_q == POR_LAST) begin
                    state_d   = RUN;
                    por_cnt_d = '0;
                end else begin
                    por_cnt_d = por_cnt_q + POR_W'(1);
                end
            end
            RUN: begin
                if (masked_c) begin
                    state_d     = PULSE;
                    pulse_cnt_d = PULSE_LOAD;
                end
            end
            PULSE: begin
                if (masked_c) begin
                    pulse_cnt_d = PULSE_LOAD;
                end else if (pulse_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    pulse_cnt_d = pulse_cnt_q - PULSE_W'(1);
                end
            end
            default: state_d = WAIT_LOCK;
        endcase
        if (!lk_c) begin
            state_d   = WAIT_LOCK;
            por_cnt_d = '0;
        end
        reset_out_d = (state_d != RUN);
        ready_d     = (state_d == RUN) || (state_d == PULSE);
    end

    // State and registered output flops.
    always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
        if (!io_asyncReset_n) begin
            lk_sync_q   <= '0;
            state_q     <= WAIT_LOCK;
            por_cnt_q   <= '0;
            pulse_cnt_q <= '0;
            reset_out_q <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            lk_sync_q   <= lk_sync_d;
            state_q     <= state_d;
            por_cnt_q   <= por_cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
            reset_out_q <= reset_out_d;
            ready_q     <= ready_d;
        end
    end

    assign io_resetOut = reset_out_q;
    assign io_ready    = ready_q;

endmodule
